// File: rtl/atm_pkg.sv
// ============================================================================
// atm_pkg : keypad codes and PIN-verifier state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package atm_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_VERIFIED = 3'd3,
        ST_EJECT    = 3'd4,
        ST_LOCKED   = 3'd5
    } pin_state_t;

endpackage

`default_nettype wire

// File: rtl/atm_timeout_counter.sv
// ============================================================================
// atm_timeout_counter : inactivity down-counter, expire fires after
//                       TIMEOUT_CYC enabled clocks without a load
// Rev 1.0
// ============================================================================
`default_nettype none

module atm_timeout_counter #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int              CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    // A load in the same cycle masks expiry: a key always beats the timer.
    assign expire_o = en_i && !load_i && (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD_VAL;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/atm_pin_verifier.sv
// ============================================================================
// atm_pin_verifier : keypad PIN collection, comparison, retry limit, timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module atm_pin_verifier
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              card_present,
    input  logic [4*PIN_DIGITS-1:0]           ref_pin,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    output logic                              pin_verified,
    output logic                              pin_bad,
    output logic                              pin_timeout,
    output logic                              card_retain,
    output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left,
    output logic [$clog2(PIN_DIGITS+1)-1:0]   digit_count
);

    localparam int            PW         = 4 * PIN_DIGITS;
    localparam int            TW         = $clog2(MAX_TRIES + 1);
    localparam int            CW         = $clog2(PIN_DIGITS + 1);
    localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
    localparam logic [CW-1:0] DIGITS_MAX = CW'(PIN_DIGITS);

    pin_state_t     state_q;
    logic [PW-1:0]  ref_q;
    logic [PW-1:0]  entry_q;
    logic [CW-1:0]  count_q;
    logic [TW-1:0]  tries_q;
    logic           verified_q;
    logic           bad_q;
    logic           timeout_q;
    logic           retain_q;
    logic           key_valid_q;
    logic [3:0]     key_code_q;

    logic           key_hit;
    logic           pin_match;
    logic           timer_load;
    logic           timer_en;
    logic           timer_expire;

    // Keys pass through one input register, so a result lands two edges after the enter strobe.
    assign key_hit   = key_valid_q && (key_code_q <= KEY_CANCEL);
    assign pin_match = (entry_q == ref_q);

    assign timer_en   = (state_q == ST_COLLECT) && card_present;
    assign timer_load = card_present &&
                        (((state_q == ST_IDLE)) ||
                         ((state_q == ST_COLLECT) && key_hit) ||
                         ((state_q == ST_CHECK) && !pin_match && (tries_q > TW'(1))));

    atm_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            entry_q     <= '0;
            count_q     <= '0;
            tries_q     <= TRIES_INIT;
            verified_q  <= 1'b0;
            bad_q       <= 1'b0;
            timeout_q   <= 1'b0;
            retain_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= key_valid;
            key_code_q  <= key_code;
            bad_q       <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (card_present) begin
                        state_q <= ST_COLLECT;
                        ref_q   <= ref_pin;
                        entry_q <= '0;
                        count_q <= '0;
                        tries_q <= TRIES_INIT;
                    end
                end

                ST_COLLECT: begin
                    if (!card_present) begin
                        state_q    <= ST_IDLE;
                        entry_q    <= '0;
                        count_q    <= '0;
                        verified_q <= 1'b0;
                    end else if (key_hit) begin
                        case (key_code_q)
                            KEY_CLEAR: begin
                                entry_q <= '0;
                                count_q <= '0;
                            end
                            KEY_ENTER: begin
                                if (count_q == DIGITS_MAX) begin
                                    state_q <= ST_CHECK;
                                end
                            end
                            KEY_CANCEL: begin
                                state_q <= ST_EJECT;
                            end
                            default: begin
                                if (count_q < DIGITS_MAX) begin
                                    entry_q <= (entry_q << 4) | PW'(key_code_q);
                                    count_q <= count_q + CW'(1);
                                end
                            end
                        endcase
                    end else if (timer_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_EJECT;
                    end
                end

                ST_CHECK: begin
                    if (!card_present) begin
                        state_q    <= ST_IDLE;
                        entry_q    <= '0;
                        count_q    <= '0;
                        verified_q <= 1'b0;
                    end else if (pin_match) begin
                        verified_q <= 1'b1;
                        state_q    <= ST_VERIFIED;
                    end else if (tries_q > TW'(1)) begin
                        tries_q <= tries_q - TW'(1);
                        bad_q   <= 1'b1;
                        entry_q <= '0;
                        count_q <= '0;
                        state_q <= ST_COLLECT;
                    end else begin
                        tries_q  <= '0;
                        retain_q <= 1'b1;
                        state_q  <= ST_LOCKED;
                    end
                end

                ST_VERIFIED, ST_EJECT: begin
                    if (!card_present) begin
                        state_q    <= ST_IDLE;
                        entry_q    <= '0;
                        count_q    <= '0;
                        verified_q <= 1'b0;
                    end
                end

                ST_LOCKED: begin
                    state_q <= ST_LOCKED;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pin_verified = verified_q;
    assign pin_bad      = bad_q;
    assign pin_timeout  = timeout_q;
    assign card_retain  = retain_q;
    assign tries_left   = tries_q;
    assign digit_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_atm_pin_verifier.sv
// ============================================================================
// tb_atm_pin_verifier : directed and random checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_atm_pin_verifier;

    localparam int PIN = 4;
    localparam int MAXT = 3;
    localparam int TCYC = 20;
    localparam int PW = 4 * PIN;

    logic          clk = 1'b0;
    logic          reset;
    logic          card_present;
    logic [PW-1:0] ref_pin;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          pin_verified, pin_bad, pin_timeout, card_retain;
    logic [1:0]    tries_left;
    logic [2:0]    digit_count;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    atm_pin_verifier #(
        .PIN_DIGITS  (PIN),
        .MAX_TRIES   (MAXT),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .card_present (card_present),
        .ref_pin      (ref_pin),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .pin_verified (pin_verified),
        .pin_bad      (pin_bad),
        .pin_timeout  (pin_timeout),
        .card_retain  (card_retain),
        .tries_left   (tries_left),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-edge rules, entry held as a queue of digits.
    typedef enum int {M_IDLE, M_COLLECT, M_CHECK, M_VERIFIED, M_EJECT, M_LOCKED} mstate_t;
    mstate_t       m_st;
    logic [3:0]    m_entry[$];
    logic [PW-1:0] m_ref;
    int            m_idle, m_tries;
    logic          m_ver, m_bad, m_to, m_ret;
    logic          m_pkv;
    logic [3:0]    m_pkc;

    function automatic logic [PW-1:0] entry_value();
        logic [PW-1:0] v = '0;
        foreach (m_entry[i]) v = v * 16 + PW'(m_entry[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_entry.delete(); m_ref = '0; m_idle = 0; m_tries = MAXT;
        m_ver = 0; m_bad = 0; m_to = 0; m_ret = 0; m_pkv = 0; m_pkc = 0;
    endtask

    task automatic model_go_idle();
        m_st = M_IDLE; m_entry.delete(); m_ver = 0;
    endtask

    task automatic model_edge();
        logic       pv = m_pkv;
        logic [3:0] pc = m_pkc;
        m_pkv = key_valid; m_pkc = key_code;
        m_bad = 0; m_to = 0;
        case (m_st)
            M_IDLE: if (card_present) begin
                m_st = M_COLLECT; m_ref = ref_pin; m_entry.delete(); m_tries = MAXT; m_idle = 0;
            end
            M_COLLECT: begin
                if (!card_present) model_go_idle();
                else if (pv && pc <= 4'hC) begin
                    m_idle = 0;
                    if (pc <= 4'd9) begin
                        if (m_entry.size() < PIN) m_entry.push_back(pc);
                    end else if (pc == 4'hA) m_entry.delete();
                    else if (pc == 4'hB) begin
                        if (m_entry.size() == PIN) m_st = M_CHECK;
                    end else m_st = M_EJECT;
                end else begin
                    m_idle++;
                    if (m_idle == TCYC) begin m_to = 1; m_st = M_EJECT; end
                end
            end
            M_CHECK: begin
                if (!card_present) model_go_idle();
                else if (entry_value() == m_ref) begin m_ver = 1; m_st = M_VERIFIED; end
                else if (m_tries > 1) begin
                    m_tries--; m_bad = 1; m_entry.delete(); m_idle = 0; m_st = M_COLLECT;
                end else begin m_tries = 0; m_ret = 1; m_st = M_LOCKED; end
            end
            M_VERIFIED, M_EJECT: if (!card_present) model_go_idle();
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pin_verified", 32'(pin_verified), 32'(m_ver));
        chk("pin_bad",      32'(pin_bad),      32'(m_bad));
        chk("pin_timeout",  32'(pin_timeout),  32'(m_to));
        chk("card_retain",  32'(card_retain),  32'(m_ret));
        chk("tries_left",   32'(tries_left),   32'(m_tries));
        chk("digit_count",  32'(digit_count),  32'(m_entry.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1; key_code = k;
        tick();
        key_valid = 1'b0; key_code = 4'h0;
    endtask

    task automatic enter_pin(input logic [PW-1:0] v);
        logic [PW-1:0] t = v;
        for (int i = PIN - 1; i >= 0; i--) press(t[i*4 +: 4]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    task automatic insert(input logic [PW-1:0] r);
        ref_pin = r; card_present = 1'b1;
        tick();
    endtask

    task automatic remove();
        card_present = 1'b0;
        tick();
    endtask

    function automatic logic [PW-1:0] rand_pin();
        logic [PW-1:0] v = '0;
        for (int i = 0; i < PIN; i++) v = v * 16 + PW'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; card_present = 1'b0; ref_pin = '0; key_valid = 1'b0; key_code = 4'h0;
        #12;
        model_reset();
        check_all();
        chk("reset_tries", 32'(tries_left), 32'(MAXT));
        reset = 1'b0;
        tick();

        // correct PIN first time
        insert(16'h1234);
        enter_pin(16'h1234); press(4'hB);
        tick();
        chk("t1_not_yet", 32'(pin_verified), 32'd0);
        tick();
        chk("t1_verified", 32'(pin_verified), 32'd1);
        chk("t1_tries", 32'(tries_left), 32'd3);
        remove(); tick();

        // wrong then right
        insert(16'h1234);
        enter_pin(16'h1235); press(4'hB); tick(); tick();
        chk("t2_bad", 32'(pin_bad), 32'd1);
        chk("t2_tries", 32'(tries_left), 32'd2);
        chk("t2_count", 32'(digit_count), 32'd0);
        enter_pin(16'h1234); press(4'hB); tick(); tick();
        chk("t2_verified", 32'(pin_verified), 32'd1);
        remove(); tick();

        // lockout
        insert(16'h1234);
        repeat (3) begin enter_pin(16'h9999); press(4'hB); tick(); tick(); end
        chk("t3_retain", 32'(card_retain), 32'd1);
        chk("t3_tries", 32'(tries_left), 32'd0);
        remove(); repeat (3) tick();
        chk("t3_retain_held", 32'(card_retain), 32'd1);
        do_reset();
        chk("t3_reset_retain", 32'(card_retain), 32'd0);
        tick();

        // clear, short enter, extra digits
        insert(16'h1234);
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4); press(4'hB);
        tick(); tick();
        chk("t4_short_ignored", 32'(digit_count), 32'd2);
        chk("t4_short_tries", 32'(tries_left), 32'd3);
        press(4'hA);
        enter_pin(16'h1234); press(4'hB); tick(); tick();
        chk("t4_verified", 32'(pin_verified), 32'd1);
        remove(); tick();
        insert(16'h1234);
        enter_pin(16'h1234); press(4'h5); press(4'h6); press(4'hE); press(4'hB); tick(); tick();
        chk("t4_extra_verified", 32'(pin_verified), 32'd1);
        remove(); tick();

        // inactivity timeout
        insert(16'h4321);
        repeat (TCYC - 1) tick();
        chk("t5_no_timeout_yet", 32'(pin_timeout), 32'd0);
        tick();
        chk("t5_timeout", 32'(pin_timeout), 32'd1);
        tick();
        chk("t5_pulse_end", 32'(pin_timeout), 32'd0);
        remove(); tick();

        // removal with enter in the same cycle
        insert(16'h1234);
        enter_pin(16'h1234);
        key_valid = 1'b1; key_code = 4'hB; card_present = 1'b0;
        tick();
        key_valid = 1'b0; key_code = 4'h0;
        tick(); tick();
        chk("t6_no_verify", 32'(pin_verified), 32'd0);
        chk("t6_no_bad", 32'(pin_bad), 32'd0);

        // reset while verified
        insert(16'h0907);
        enter_pin(16'h0907); press(4'hB); tick(); tick();
        chk("t7_verified", 32'(pin_verified), 32'd1);
        do_reset();
        chk("t7_reset_verified", 32'(pin_verified), 32'd0);
        tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                continue;
            end
            if (!card_present) begin
                if ($urandom_range(0, 7) == 0) begin
                    ref_pin = rand_pin(); card_present = 1'b1;
                end
            end else if ($urandom_range(0, 59) == 0) begin
                card_present = 1'b0;
            end
            key_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 5 && m_entry.size() < PIN)
                key_code = m_ref[(PIN - 1 - m_entry.size()) * 4 +: 4];
            else if (r < 7)
                key_code = 4'hB;
            else
                key_code = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
